// File: rtl/if_stage_pkg.sv
`default_nettype none
// ============================================================================
// Module      : if_stage_pkg
// Description : Shared definitions for the instruction-fetch stage: NOP
//               encoding, fetch FSM state encoding and response FIFO depth.
// Revision    : 1.0 - initial release
// ============================================================================
package if_stage_pkg;

    // Bubble presented to decode while no fetched instruction is available
    localparam logic [31:0] IF_NOP = 32'h0000_0013;

    // Response buffer geometry (count must be able to hold FIFO_DEPTH)
    localparam int FIFO_DEPTH = 2;
    localparam int FIFO_CNT_W = 2;

    // REQ  : no request outstanding, may issue
    // WAIT : one request outstanding, its response will be kept
    // KILL : one request outstanding, its response will be discarded
    typedef enum logic [1:0] {
        ST_REQ  = 2'd0,
        ST_WAIT = 2'd1,
        ST_KILL = 2'd2
    } if_state_e;

endpackage : if_stage_pkg
`default_nettype wire

// File: rtl/if_stage_fetch_fifo.sv
`default_nettype none
// ============================================================================
// Module      : fetch_fifo
// Description : Two-entry FIFO of {instruction, pc} pairs between the memory
//               response and decode. Flush has priority over push/pop.
// Ports       : clk, rst       - clock, synchronous active-high reset
//               i_push, i_data, i_pc - write one entry
//               i_pop          - remove head entry
//               i_flush        - discard all entries
//               o_count        - number of stored entries
//               o_head_data, o_head_pc - head entry (valid when o_count != 0)
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_fifo
    import if_stage_pkg::*;
#(
    parameter int WORD_SIZE = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_push,
    input  logic [WORD_SIZE-1:0]  i_data,
    input  logic [WORD_SIZE-1:0]  i_pc,
    input  logic                  i_pop,
    input  logic                  i_flush,
    output logic [FIFO_CNT_W-1:0] o_count,
    output logic [WORD_SIZE-1:0]  o_head_data,
    output logic [WORD_SIZE-1:0]  o_head_pc
);

    logic [WORD_SIZE-1:0]  r_data [FIFO_DEPTH];
    logic [WORD_SIZE-1:0]  r_pc   [FIFO_DEPTH];
    logic                  r_rd_ptr;
    logic                  r_wr_ptr;
    logic [FIFO_CNT_W-1:0] r_count;

    logic w_pop;
    logic w_push;

    assign w_pop  = i_pop && (r_count != '0);
    // When full, a same-cycle pop frees the slot the write pointer lands on
    assign w_push = i_push && ((r_count != FIFO_CNT_W'(FIFO_DEPTH)) || w_pop);

    always_ff @(posedge clk) begin
        if (rst || i_flush) begin
            r_rd_ptr <= 1'b0;
            r_wr_ptr <= 1'b0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + FIFO_CNT_W'(1);
                2'b01:   r_count <= r_count - FIFO_CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset: contents are qualified by r_count
    always_ff @(posedge clk) begin
        if (w_push && !rst && !i_flush) begin
            r_data[r_wr_ptr] <= i_data;
            r_pc[r_wr_ptr]   <= i_pc;
        end
    end

    assign o_count     = r_count;
    assign o_head_data = r_data[r_rd_ptr];
    assign o_head_pc   = r_pc[r_rd_ptr];

endmodule : fetch_fifo
`default_nettype wire

// File: rtl/if_stage.sv
`default_nettype none
// ============================================================================
// Module      : if_stage
// Description : Instruction-fetch stage. Keeps the fetch PC, issues at most
//               one instruction-memory request at a time, buffers responses
//               in a 2-entry FIFO and presents them in order to decode.
//               Redirects flush everything and restart fetch at the target.
// Ports       : clk, rst            - clock, synchronous active-high reset
//               redirect, redirect_pc - load new fetch PC (byte address)
//               instr_ready         - decode accepts instr this cycle
//               imem_req, imem_addr - fetch request pulse, word address
//               imem_rvalid, imem_rdata - memory response
//               instr, instr_pc, instr_valid - instruction to decode
//               fetch_fault         - misaligned redirect trap
// Config      : IF_MISALIGN_TRAP_EN - when defined, a redirect to a
//               non-word-aligned target raises a sticky fetch_fault and
//               stops fetching until an aligned redirect or reset. When
//               undefined, redirect_pc[1:0] is ignored and fetch_fault = 0.
// Revision    : 1.0 - initial release
// ============================================================================
module if_stage
    import if_stage_pkg::*;
#(
    parameter int                   WORD_SIZE = 32,
    parameter int                   ADDR_SIZE = 10,
    parameter logic [WORD_SIZE-1:0] RESET_PC  = 32'h0000_0000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 redirect,
    input  logic [WORD_SIZE-1:0] redirect_pc,
    input  logic                 instr_ready,
    output logic                 imem_req,
    output logic [ADDR_SIZE-1:0] imem_addr,
    input  logic                 imem_rvalid,
    input  logic [WORD_SIZE-1:0] imem_rdata,
    output logic [WORD_SIZE-1:0] instr,
    output logic [WORD_SIZE-1:0] instr_pc,
    output logic                 instr_valid,
    output logic                 fetch_fault
);

    if_state_e             r_state;
    logic [WORD_SIZE-1:0]  r_pc;

    logic [WORD_SIZE-1:0]  w_tgt;
    logic                  w_issue;
    logic                  w_push;
    logic                  w_pop;
    logic [FIFO_CNT_W-1:0] w_count;
    logic [WORD_SIZE-1:0]  w_head_data;
    logic [WORD_SIZE-1:0]  w_head_pc;

`ifdef IF_MISALIGN_TRAP_EN
    logic r_fault;

    // Sticky until reset or the next redirect, which re-evaluates alignment
    always_ff @(posedge clk) begin
        if (rst) begin
            r_fault <= 1'b0;
        end else if (redirect) begin
            r_fault <= |redirect_pc[1:0];
        end
    end

    assign w_tgt       = redirect_pc;
    assign fetch_fault = r_fault;
`else
    logic [1:0] w_unused_rpc_lo;

    assign w_unused_rpc_lo = redirect_pc[1:0];
    assign w_tgt           = {redirect_pc[WORD_SIZE-1:2], 2'b00};
    assign fetch_fault     = 1'b0;
`endif

    // In REQ nothing is outstanding, so FIFO space alone gates the issue.
    // A same-cycle pop is deliberately not credited.
    assign w_issue = !rst && !redirect && !fetch_fault && (r_state == ST_REQ)
                     && (w_count < FIFO_CNT_W'(FIFO_DEPTH));

    // Only a response to a live request is kept; anything seen in REQ or
    // KILL (including a straggler from before reset) is dropped.
    assign w_push  = !rst && !redirect && (r_state == ST_WAIT) && imem_rvalid;
    assign w_pop   = instr_valid && instr_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_REQ;
            r_pc    <= RESET_PC;
        end else if (redirect) begin
            r_pc <= w_tgt;
            case (r_state)
                ST_WAIT: r_state <= imem_rvalid ? ST_REQ : ST_KILL;
                ST_KILL: r_state <= imem_rvalid ? ST_REQ : ST_KILL;
                default: r_state <= ST_REQ;
            endcase
        end else begin
            case (r_state)
                ST_REQ: begin
                    if (w_issue) begin
                        r_state <= ST_WAIT;
                        r_pc    <= r_pc + WORD_SIZE'(4);
                    end
                end
                ST_WAIT: begin
                    if (imem_rvalid) begin
                        r_state <= ST_REQ;
                    end
                end
                ST_KILL: begin
                    if (imem_rvalid) begin
                        r_state <= ST_REQ;
                    end
                end
                default: r_state <= ST_REQ;
            endcase
        end
    end

    // r_pc has already advanced past the outstanding request
    fetch_fifo #(
        .WORD_SIZE (WORD_SIZE)
    ) u_fetch_fifo (
        .clk         (clk),
        .rst         (rst),
        .i_push      (w_push),
        .i_data      (imem_rdata),
        .i_pc        (r_pc - WORD_SIZE'(4)),
        .i_pop       (w_pop),
        .i_flush     (redirect),
        .o_count     (w_count),
        .o_head_data (w_head_data),
        .o_head_pc   (w_head_pc)
    );

    assign imem_req    = w_issue;
    assign imem_addr   = r_pc[ADDR_SIZE+1:2];
    assign instr_valid = (w_count != '0);
    assign instr       = instr_valid ? w_head_data : WORD_SIZE'(IF_NOP);
    assign instr_pc    = instr_valid ? w_head_pc : '0;

endmodule : if_stage
`default_nettype wire

// File: tb/tb_if_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_if_stage
// Description : Self-checking bench for if_stage: directed vector table,
//               multi-cycle corner sequences and a randomized run against a
//               program-order reference model with a latency-varying memory.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_if_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        instr_ready;
    logic        imem_req;
    logic [9:0]  imem_addr;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_valid;
    logic        fetch_fault;

    always #5 clk = ~clk;

    if_stage #(
        .WORD_SIZE (32),
        .ADDR_SIZE (10),
        .RESET_PC  (32'h0000_0000)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .instr_ready (instr_ready),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .instr_valid (instr_valid),
        .fetch_fault (fetch_fault)
    );

    int checks   = 0;
    int failures = 0;

    // Memory model: one pending request, random latency
    bit         mem_auto    = 1'b0;
    bit         mem_pend    = 1'b0;
    int         mem_cnt     = 0;
    int         mem_lat_max = 1;
    logic [9:0] mem_a       = '0;

    typedef struct {
        logic        redir;
        logic [31:0] rpc;
        logic        rdy;
        logic        rv;
        logic [31:0] rdata;
        logic        e_req;
        logic [9:0]  e_addr;
        logic        e_valid;
        logic [31:0] e_instr;
        logic [31:0] e_pc;
    } vec_t;

    vec_t vt [24];

    function automatic logic [31:0] mem_word(input logic [9:0] a);
        return {6'h2A, a, 6'h15, a};
    endfunction

    function automatic vec_t mk(input logic rd, input logic [31:0] rp, input logic rdy,
                                input logic rv, input logic [31:0] rdat, input logic er,
                                input logic [9:0] ea, input logic ev,
                                input logic [31:0] ei, input logic [31:0] ep);
        vec_t v;
        v.redir = rd;  v.rpc = rp;     v.rdy = rdy;    v.rv = rv;       v.rdata = rdat;
        v.e_req = er;  v.e_addr = ea;  v.e_valid = ev; v.e_instr = ei;  v.e_pc = ep;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic mem_drive();
        imem_rvalid = 1'b0;
        imem_rdata  = '0;
        if (mem_auto && mem_pend) begin
            mem_cnt--;
            if (mem_cnt <= 0) begin
                imem_rvalid = 1'b1;
                imem_rdata  = mem_word(mem_a);
                mem_pend    = 1'b0;
            end
        end
    endtask

    task automatic mem_sample();
        if (mem_auto && imem_req && !rst) begin
            mem_pend = 1'b1;
            mem_cnt  = $urandom_range(mem_lat_max, 1);
            mem_a    = imem_addr;
        end
    endtask

    task automatic next_cycle();
        mem_sample();
        @(posedge clk);
        #1;
        mem_drive();
    endtask

    task automatic do_reset();
        rst         = 1'b1;
        redirect    = 1'b0;
        redirect_pc = '0;
        instr_ready = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata  = '0;
        mem_pend    = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic wait_req(input string name, input logic [9:0] ea);
        bit found = 1'b0;
        for (int i = 0; i < 8 && !found; i++) begin
            @(negedge clk);
            if (imem_req) begin
                found = 1'b1;
                check(name, 32'(imem_addr), 32'(ea));
            end
            next_cycle();
        end
        check({name, "_seen"}, 32'(found), 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int          nreq;
        int          got;
        int          accepted;
        bit          last_req;
        bit          post;
        logic [31:0] exp_pc;
        logic [31:0] exp_fetch;

        vt[0]  = mk(0, 0,      1, 0, 0,            1, 10'h000, 0, NOP,          0);
        vt[1]  = mk(0, 0,      1, 1, 32'hD000_0000, 0, 10'h001, 0, NOP,          0);
        vt[2]  = mk(0, 0,      1, 0, 0,            1, 10'h001, 1, 32'hD000_0000, 32'h0);
        vt[3]  = mk(0, 0,      1, 1, 32'hD000_0001, 0, 10'h002, 0, NOP,          0);
        vt[4]  = mk(0, 0,      1, 0, 0,            1, 10'h002, 1, 32'hD000_0001, 32'h4);
        vt[5]  = mk(0, 0,      1, 1, 32'hD000_0002, 0, 10'h003, 0, NOP,          0);
        vt[6]  = mk(0, 0,      1, 0, 0,            1, 10'h003, 1, 32'hD000_0002, 32'h8);
        vt[7]  = mk(1, 32'h100, 1, 0, 0,            0, 10'h004, 0, NOP,          0);
        vt[8]  = mk(0, 0,      1, 0, 0,            0, 10'h040, 0, NOP,          0);
        vt[9]  = mk(0, 0,      1, 1, 32'hD000_0003, 0, 10'h040, 0, NOP,          0);
        vt[10] = mk(0, 0,      1, 0, 0,            1, 10'h040, 0, NOP,          0);
        vt[11] = mk(0, 0,      1, 1, 32'hD000_0004, 0, 10'h041, 0, NOP,          0);
        vt[12] = mk(0, 0,      1, 0, 0,            1, 10'h041, 1, 32'hD000_0004, 32'h100);
        vt[13] = mk(1, 32'h100, 1, 1, 32'hD000_0005, 0, 10'h042, 0, NOP,          0);
        vt[14] = mk(0, 0,      1, 0, 0,            1, 10'h040, 0, NOP,          0);
        vt[15] = mk(0, 0,      1, 1, 32'hD000_0006, 0, 10'h041, 0, NOP,          0);
        vt[16] = mk(0, 0,      0, 0, 0,            1, 10'h041, 1, 32'hD000_0006, 32'h100);
        vt[17] = mk(0, 0,      0, 1, 32'hD000_0007, 0, 10'h042, 1, 32'hD000_0006, 32'h100);
        vt[18] = mk(0, 0,      0, 0, 0,            0, 10'h042, 1, 32'hD000_0006, 32'h100);
        vt[19] = mk(0, 0,      0, 0, 0,            0, 10'h042, 1, 32'hD000_0006, 32'h100);
        vt[20] = mk(0, 0,      1, 0, 0,            0, 10'h042, 1, 32'hD000_0006, 32'h100);
        vt[21] = mk(0, 0,      1, 0, 0,            1, 10'h042, 1, 32'hD000_0007, 32'h104);
        vt[22] = mk(0, 0,      1, 1, 32'hD000_0008, 0, 10'h043, 0, NOP,          0);
        vt[23] = mk(0, 0,      1, 0, 0,            1, 10'h043, 1, 32'hD000_0008, 32'h108);

        // ---------------- reset state ----------------
        rst = 1'b1; redirect = 1'b0; redirect_pc = '0; instr_ready = 1'b0;
        imem_rvalid = 1'b0; imem_rdata = '0;
        @(posedge clk); #1;
        @(negedge clk);
        check("rst_req",   32'(imem_req),    32'd0);
        check("rst_valid", 32'(instr_valid), 32'd0);
        check("rst_instr", instr,            NOP);
        check("rst_pc",    instr_pc,         32'd0);
        check("rst_fault", 32'(fetch_fault), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // ---------------- directed vector table ----------------
        for (int i = 0; i < 24; i++) begin
            redirect    = vt[i].redir;
            redirect_pc = vt[i].rpc;
            instr_ready = vt[i].rdy;
            imem_rvalid = vt[i].rv;
            imem_rdata  = vt[i].rdata;
            @(negedge clk);
            check($sformatf("v%0d_req", i),   32'(imem_req),    32'(vt[i].e_req));
            check($sformatf("v%0d_addr", i),  32'(imem_addr),   32'(vt[i].e_addr));
            check($sformatf("v%0d_valid", i), 32'(instr_valid), 32'(vt[i].e_valid));
            check($sformatf("v%0d_instr", i), instr,            vt[i].e_instr);
            check($sformatf("v%0d_ipc", i),   instr_pc,         vt[i].e_pc);
            @(posedge clk); #1;
        end

        // ---------------- decode stall: buffer fills, fetch stops ----------------
        do_reset();
        mem_auto = 1'b1; mem_lat_max = 1; instr_ready = 1'b0;
        nreq = 0; last_req = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (imem_req) nreq++;
            last_req = imem_req;
            next_cycle();
        end
        check("stall_nreq",    32'(nreq),     32'd2);
        check("stall_req_off", 32'(last_req), 32'd0);
        instr_ready = 1'b1;
        exp_pc = 32'h0; got = 0;
        for (int i = 0; i < 20 && got < 3; i++) begin
            @(negedge clk);
            if (instr_valid) begin
                check("stall_rel_pc",    instr_pc, exp_pc);
                check("stall_rel_instr", instr,    mem_word(exp_pc[11:2]));
                exp_pc += 32'd4;
                got++;
            end
            next_cycle();
        end
        check("stall_rel_count", 32'(got), 32'd3);

        // ---------------- reset while a request is outstanding ----------------
        mem_auto = 1'b0;
        do_reset();
        @(negedge clk);
        check("rw_first_req", 32'(imem_req), 32'd1);
        @(posedge clk); #1;
        imem_rvalid = 1'b1; imem_rdata = 32'h0000_00A1;
        @(posedge clk); #1;
        imem_rvalid = 1'b0;
        @(negedge clk);
        check("rw_pre_valid", 32'(instr_valid), 32'd1);
        check("rw_pre_req",   32'(imem_req),    32'd1);
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        check("rw_rst_req", 32'(imem_req), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h0000_0BAD;
        @(negedge clk);
        check("rw_post_valid", 32'(instr_valid), 32'd0);
        check("rw_post_instr", instr,            NOP);
        check("rw_post_pc",    instr_pc,         32'd0);
        check("rw_post_fault", 32'(fetch_fault), 32'd0);
        check("rw_post_req",   32'(imem_req),    32'd1);
        check("rw_post_addr",  32'(imem_addr),   32'd0);
        @(posedge clk); #1;
        imem_rvalid = 1'b0;
        @(negedge clk);
        check("rw_stale_dropped", 32'(instr_valid), 32'd0);
        @(posedge clk); #1;
        imem_rvalid = 1'b1; imem_rdata = 32'h0000_00A2;
        @(posedge clk); #1;
        imem_rvalid = 1'b0;
        @(negedge clk);
        check("rw_new_valid", 32'(instr_valid), 32'd1);
        check("rw_new_instr", instr,            32'h0000_00A2);
        check("rw_new_pc",    instr_pc,         32'd0);
        @(posedge clk); #1;

        // ---------------- misaligned redirect ----------------
        do_reset();
        mem_auto = 1'b1; mem_lat_max = 1; instr_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            next_cycle();
        end
        redirect = 1'b1; redirect_pc = 32'h0000_0102;
        @(negedge clk);
        check("mis_redir_req", 32'(imem_req), 32'd0);
        next_cycle();
        redirect = 1'b0;
`ifdef IF_MISALIGN_TRAP_EN
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("mis_fault_set", 32'(fetch_fault), 32'd1);
            check("mis_halted",    32'(imem_req),    32'd0);
            next_cycle();
        end
        redirect = 1'b1; redirect_pc = 32'h0000_0104;
        @(negedge clk);
        next_cycle();
        redirect = 1'b0;
        @(negedge clk);
        check("mis_fault_clr", 32'(fetch_fault), 32'd0);
        @(posedge clk); #1;
        mem_drive();
        wait_req("mis_resume_addr", 10'h041);
`else
        wait_req("mis_forced_addr", 10'h040);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("mis_no_fault", 32'(fetch_fault), 32'd0);
            next_cycle();
        end
`endif

        // ---------------- randomized run vs program-order model ----------------
        do_reset();
        mem_auto = 1'b1; mem_lat_max = 3;
        exp_pc = 32'h0; exp_fetch = 32'h0; post = 1'b0; accepted = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            instr_ready = ($urandom_range(3, 0) != 0);
            redirect    = ($urandom_range(15, 0) == 0);
            redirect_pc = {22'h0, 8'($urandom_range(255, 0)), 2'b00};
            @(negedge clk);
            if (post) check("rnd_post_redir_valid", 32'(instr_valid), 32'd0);
            if (imem_req) begin
                check("rnd_one_outstanding", 32'(mem_pend || imem_rvalid), 32'd0);
                check("rnd_req_addr", 32'(imem_addr), 32'(exp_fetch[11:2]));
                exp_fetch += 32'd4;
            end
            if (redirect) begin
                check("rnd_redir_noreq", 32'(imem_req), 32'd0);
                exp_fetch = redirect_pc;
                exp_pc    = redirect_pc;
            end else if (instr_valid && instr_ready) begin
                check("rnd_pc",    instr_pc, exp_pc);
                check("rnd_instr", instr,    mem_word(exp_pc[11:2]));
                exp_pc += 32'd4;
                accepted++;
            end
            post = redirect;
            next_cycle();
        end
        redirect = 1'b0;
        check("rnd_progress", 32'(accepted >= 300), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_if_stage
`default_nettype wire

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 SHALL have parameter WORD_SIZE, default 32, instruction/PC width.
REQ-002 SHALL have parameter ADDR_SIZE, default 10, instruction-memory word-address width.
REQ-003 SHALL have parameter RESET_PC, default 32'h0000_0000, first fetch address.
REQ-004 SHALL have port clk  input  1  single clock, all logic on rising edge.
REQ-005 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-006 SHALL have port redirect  input  1  branch/jump taken; load new PC.
REQ-007 SHALL have port redirect_pc  input  WORD_SIZE  redirect target byte address.
REQ-008 SHALL have port instr_ready  input  1  decode stage accepts instr this cycle.
REQ-009 SHALL have port imem_req  output  1  one-cycle fetch request pulse.
REQ-010 SHALL have port imem_addr  output  ADDR_SIZE  word address, pc[ADDR_SIZE+1:2].
REQ-011 SHALL have port imem_rvalid  input  1  response valid, latency >= 1 cycle after imem_req.
REQ-012 SHALL have port imem_rdata  input  WORD_SIZE  fetched instruction.
REQ-013 SHALL have port instr  output  WORD_SIZE  instruction to decode.
REQ-014 SHALL have port instr_pc  output  WORD_SIZE  byte address of instr.
REQ-015 SHALL have port instr_valid  output  1  instr/instr_pc valid.
REQ-016 SHALL have port fetch_fault  output  1  misaligned redirect (IF_MISALIGN_TRAP_EN only; else tied 0).

Function
REQ-017 SHALL hold fetch PC register; increment by 4 after each issued request.
REQ-018 SHALL keep at most one outstanding memory request.
REQ-019 SHALL buffer responses in 2-entry FIFO of {instr, pc}; issue request only when FIFO count + outstanding < 2.
REQ-020 SHALL write imem_rdata into FIFO on the cycle imem_rvalid=1; instr_valid SHALL rise next cycle (response-to-output latency 1).
REQ-021 SHALL pop FIFO head when instr_valid && instr_ready; push and pop in same cycle allowed at count 1 or 2.
REQ-022 SHALL drive instr=32'h0000_0013 (NOP) and instr_valid=0 when FIFO empty.
REQ-023 SHALL use FSM states REQ (may issue), WAIT (outstanding, await rvalid), KILL (outstanding, response to be discarded).
REQ-024 Transitions: REQ->WAIT on issue; WAIT->REQ on rvalid; WAIT->KILL on redirect without rvalid; KILL->REQ on rvalid (data dropped).
REQ-025 Redirect SHALL have priority over all events: flush FIFO, pc<=redirect_pc, drop same-cycle rvalid, no request that cycle.
REQ-026 instr_valid SHALL be 0 the cycle after redirect; first post-redirect request issues the cycle after redirect (in REQ) or after killed response returns (KILL).
REQ-027 Redirect while instr_ready pops SHALL discard the popped entry with the rest.
REQ-028 PC arithmetic SHALL wrap modulo 2^WORD_SIZE; imem_addr wraps modulo 2^ADDR_SIZE.

Reset
REQ-029 On rst: pc=RESET_PC, FSM=REQ, FIFO empty, imem_req=0, instr_valid=0, instr=NOP, instr_pc=0, fetch_fault=0.
REQ-030 Reset mid-transaction SHALL abandon outstanding request; rvalid in first post-reset cycle ignored only if request was outstanding at reset.
REQ-031 First request SHALL issue first cycle after rst deasserts.

Configuration
REQ-032 Macro IF_MISALIGN_TRAP_EN: when defined, redirect with redirect_pc[1:0]!=0 SHALL set fetch_fault sticky until next rst or aligned redirect, and halt fetching; when undefined, redirect_pc[1:0] ignored (forced 0), fetch_fault constant 0.

Structure
REQ-033 Shared defines file SHALL hold NOP encoding, FSM state encodings, FIFO depth constant.
REQ-034 SHALL instantiate one sub-module, fetch_fifo (2-entry, push/pop/flush, count).

Verification
REQ-035 Reset, rvalid 1 cycle after each req, instr_ready=1 -> imem_addr 0,1,2,3...; instr_pc 0x0,0x4,0x8 one per 2 cycles.
REQ-036 instr_ready=0 for 6 cycles -> exactly 2 entries buffered, imem_req stops, no data lost; release -> in-order PCs.
REQ-037 redirect to 0x100 while WAIT -> next rvalid dropped, next instr_pc=0x100, no stale instr_valid.
REQ-038 redirect same cycle as rvalid -> data dropped, FIFO empty next cycle, next imem_addr=0x40 for target 0x100.
REQ-039 rst asserted in WAIT -> outputs at reset values next cycle, first fetch at RESET_PC.
REQ-040 With IF_MISALIGN_TRAP_EN, redirect to 0x102 -> fetch_fault=1, imem_req=0 until aligned redirect to 0x104.
